key_event_fsm: RTL and testbench
================================

KEY_EVENT_FSM -- requirements
Module: key_event_fsm

Interface
REQ-001 The block SHALL have parameter FREQ, default 50, meaning clock frequency in MHz.
REQ-002 The block SHALL have parameter LONG_MS, default 1000, meaning hold time in ms before a long press is reported.
REQ-003 The block SHALL have parameter REPEAT_MS, default 200, meaning auto-repeat period in ms while long-held.
REQ-004 The block SHALL have parameter DCLICK_MS, default 300, meaning maximum release-to-second-press gap in ms for a double press (0 disables double-press detection).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning system clock.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port key_press, input, 1 bit, meaning one-cycle pulse for the debounced key going pressed (falling level).
REQ-008 The block SHALL have port key_release, input, 1 bit, meaning one-cycle pulse for the debounced key going released (rising level).
REQ-009 The block SHALL have port short_press, output, 1 bit, meaning one-cycle pulse for a single short click.
REQ-010 The block SHALL have port double_press, output, 1 bit, meaning one-cycle pulse for two short clicks within DCLICK_MS.
REQ-011 The block SHALL have port long_press, output, 1 bit, meaning one-cycle pulse when the hold reaches LONG_MS.
REQ-012 The block SHALL have port repeat_press, output, 1 bit, meaning one-cycle pulse every REPEAT_MS after long_press while still held.
REQ-013 The block SHALL have port key_held, output, 1 bit, meaning level, high while the FSM considers the key pressed.

Function
REQ-014 The block SHALL derive a 1 ms tick from a prescaler counting FREQ*1000 cycles, synchronously cleared whenever the ms counter is cleared.
REQ-015 The block SHALL implement FSM states IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
REQ-016 IDLE: on key_press, the FSM SHALL go to PRESSED and clear the timers.
REQ-017 PRESSED: on key_release before LONG_MS, the FSM SHALL go to WAIT_SECOND and clear the timers; if DCLICK_MS=0, it SHALL instead pulse short_press and go to IDLE.
REQ-018 PRESSED/SECOND_PRESSED: when the ms count reaches LONG_MS, the FSM SHALL pulse long_press, go to LONG_HELD and clear the timers, and SHALL NOT later report short or double press for this press.
REQ-019 LONG_HELD: the FSM SHALL pulse repeat_press each time the ms count reaches REPEAT_MS and restart the count; on key_release it SHALL go to IDLE with no other pulse.
REQ-020 WAIT_SECOND: on key_press before DCLICK_MS, the FSM SHALL go to SECOND_PRESSED and clear the timers; on timeout it SHALL pulse short_press and go to IDLE.
REQ-021 SECOND_PRESSED: on key_release before LONG_MS, the FSM SHALL pulse double_press and go to IDLE.
REQ-022 The long-press pulse SHALL be asserted exactly LONG_MS*FREQ*1000 cycles after the edge that sampled key_press; timing SHALL be exact, with no ±1 ms drift from a free-running prescaler.
REQ-023 key_press and key_release asserted in the same cycle SHALL both be ignored; key_release in IDLE or WAIT_SECOND, and key_press in any pressed state, SHALL be ignored.
REQ-024 All outputs SHALL be registered, and at most one of short/double/long/repeat SHALL be high in any cycle.
REQ-025 key_held SHALL be high in PRESSED, SECOND_PRESSED and LONG_HELD, and low otherwise.
REQ-026 The ms counter SHALL be 16 bits and SHALL saturate rather than wrap.

Reset
REQ-027 On rst low, the block SHALL asynchronously force state IDLE, clear prescaler and ms counter, and drive all outputs to 0.
REQ-028 A reset mid-press SHALL produce no pulse after release; the next event SHALL be recognised only after a fresh key_press.

Structure
REQ-029 State encoding and the TICKS_PER_MS calculation SHALL reside in shared package key_event_pkg.
REQ-030 The prescaler SHALL be sub-module ms_tick_gen (inputs clk, rst, clr; output tick).

Verification (FREQ=1, LONG_MS=10, REPEAT_MS=4, DCLICK_MS=5; 1000 cycles/ms)
REQ-031 Bench SHALL cover: press, release at 3 ms -> short_press 5000 cycles after release, no other pulse.
REQ-032 Bench SHALL cover: press 2 ms, release, press again 2 ms later, release after 1 ms -> double_press 1 cycle after second release, no short_press.
REQ-033 Bench SHALL cover: hold 19 ms -> long_press at 10000 cycles, repeat_press at 14000 and 18000; release -> no short_press.
REQ-034 Bench SHALL cover: key_press and key_release asserted same cycle in IDLE -> state stays IDLE, no outputs.
REQ-035 Bench SHALL cover: rst pulsed low at 6 ms of hold, release at 8 ms -> all outputs 0, key_held 0, no pulses.
REQ-036 Bench SHALL cover: DCLICK_MS=0, press 1 ms, release -> short_press 1 cycle after release.

Source files
------------

// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_pkg
//  Description : Shared state encoding and timing helpers for the key event
//                classifier (short / double / long / repeat press).
//  Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

    // Width of the millisecond counter; it saturates at all-ones.
    localparam int MS_W = 16;

    // Classifier states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_t;

    // Number of clock cycles in one millisecond for a clock given in MHz.
    function automatic int ticks_per_ms(input int freq_mhz);
        return freq_mhz * 1000;
    endfunction

endpackage : key_event_pkg
`default_nettype wire

// File: rtl/key_event_fsm_tick.sv
`default_nettype none
// ============================================================================
//  Module      : ms_tick_gen
//  Description : Millisecond prescaler. Asserts tick in the last cycle of each
//                TICKS-cycle period; clr restarts the period so that timing is
//                measured from the clearing edge rather than a free-running
//                phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
    parameter int TICKS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Period counter: wraps on tick, restarts whenever the ms timer is cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/key_event_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_fsm
//  Description : Classifies debounced key press/release pulses into short,
//                double, long and auto-repeat press events. All event outputs
//                are registered one-cycle pulses; key_held is a registered
//                level.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int FREQ      = 50,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int DCLICK_MS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic key_press,
    input  logic key_release,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_press,
    output logic key_held
);

    localparam int TPM       = ticks_per_ms(FREQ);
    localparam bit DCLICK_EN = (DCLICK_MS > 0);

    // "Count reaches N" is detected on the tick that moves the count to N,
    // so the comparisons use N-1 and the event lands exactly N ms after the
    // clearing edge.
    localparam logic [MS_W-1:0] LONG_LAST   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] REPEAT_LAST = MS_W'(REPEAT_MS - 1);
    localparam logic [MS_W-1:0] DCLICK_LAST = MS_W'(DCLICK_EN ? DCLICK_MS - 1 : 0);

    state_t          state;
    state_t          next_state;
    logic [MS_W-1:0] ms_cnt;
    logic            tick;
    logic            clr;
    logic            press_ev;
    logic            rel_ev;
    logic            long_hit;
    logic            rep_hit;
    logic            dclick_hit;
    logic            short_nxt;
    logic            double_nxt;
    logic            long_nxt;
    logic            repeat_nxt;
    logic            held_nxt;

    // Simultaneous press and release are contradictory and both dropped.
    assign press_ev   = key_press & ~key_release;
    assign rel_ev     = key_release & ~key_press;

    assign long_hit   = tick && (ms_cnt == LONG_LAST);
    assign rep_hit    = tick && (ms_cnt == REPEAT_LAST);
    assign dclick_hit = tick && (ms_cnt == DCLICK_LAST);

    ms_tick_gen #(
        .TICKS (TPM)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // Millisecond counter: cleared with the prescaler, saturates at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_cnt <= '0;
        end else if (clr) begin
            ms_cnt <= '0;
        end else if (tick && (ms_cnt != {MS_W{1'b1}})) begin
            ms_cnt <= ms_cnt + MS_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and timer-clear decode. A key edge arriving on the same
    // cycle as a timer expiry is honoured first, so a release is never lost.
    always_comb begin
        next_state = state;
        clr        = 1'b0;
        case (state)
            ST_IDLE: begin
                clr = 1'b1;
                if (press_ev) begin
                    next_state = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (rel_ev) begin
                    clr = 1'b1;
                    next_state = DCLICK_EN ? ST_WAIT_SECOND : ST_IDLE;
                end else if (long_hit) begin
                    clr = 1'b1;
                    next_state = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (rel_ev) begin
                    clr = 1'b1;
                    next_state = ST_IDLE;
                end else if (rep_hit) begin
                    clr = 1'b1;
                end
            end
            ST_WAIT_SECOND: begin
                if (press_ev) begin
                    clr = 1'b1;
                    next_state = ST_SECOND_PRESSED;
                end else if (dclick_hit) begin
                    clr = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            ST_SECOND_PRESSED: begin
                if (rel_ev) begin
                    clr = 1'b1;
                    next_state = ST_IDLE;
                end else if (long_hit) begin
                    clr = 1'b1;
                    next_state = ST_LONG_HELD;
                end
            end
            default: begin
                clr = 1'b1;
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output decode: at most one event pulse per cycle by construction.
    always_comb begin
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        held_nxt   = (next_state == ST_PRESSED) ||
                     (next_state == ST_SECOND_PRESSED) ||
                     (next_state == ST_LONG_HELD);
        case (state)
            ST_PRESSED: begin
                if (rel_ev) begin
                    short_nxt = !DCLICK_EN;
                end else if (long_hit) begin
                    long_nxt = 1'b1;
                end
            end
            ST_LONG_HELD: begin
                repeat_nxt = !rel_ev && rep_hit;
            end
            ST_WAIT_SECOND: begin
                short_nxt = !press_ev && dclick_hit;
            end
            ST_SECOND_PRESSED: begin
                if (rel_ev) begin
                    double_nxt = 1'b1;
                end else if (long_hit) begin
                    long_nxt = 1'b1;
                end
            end
            default: begin
                short_nxt = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            short_press  <= short_nxt;
            double_press <= double_nxt;
            long_press   <= long_nxt;
            repeat_press <= repeat_nxt;
            key_held     <= held_nxt;
        end
    end

endmodule : key_event_fsm
`default_nettype wire

// File: tb/tb_key_event_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_fsm
//  Description : Directed self-checking bench for key_event_fsm. Instance a
//                uses double-press detection, instance b has it disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_fsm;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_press = 1'b0;
    logic key_release = 1'b0;

    logic a_short, a_double, a_long, a_rep, a_held;
    logic b_short, b_double, b_long, b_rep, b_held;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    int n_short, n_double, n_long, n_rep, n_excl;
    int t_short, t_double, t_long, t_rep_first, t_rep_last;
    int nb_short, nb_other, tb_short;

    key_event_fsm #(.FREQ(1), .LONG_MS(10), .REPEAT_MS(4), .DCLICK_MS(5)) dut_a (
        .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
        .short_press(a_short), .double_press(a_double), .long_press(a_long),
        .repeat_press(a_rep), .key_held(a_held)
    );

    key_event_fsm #(.FREQ(1), .LONG_MS(10), .REPEAT_MS(4), .DCLICK_MS(0)) dut_b (
        .clk(clk), .rst(rst), .key_press(key_press), .key_release(key_release),
        .short_press(b_short), .double_press(b_double), .long_press(b_long),
        .repeat_press(b_rep), .key_held(b_held)
    );

    always #5 clk = ~clk;

    task automatic clear_counts;
        n_short = 0; n_double = 0; n_long = 0; n_rep = 0; n_excl = 0;
        t_short = -1; t_double = -1; t_long = -1; t_rep_first = -1; t_rep_last = -1;
        nb_short = 0; nb_other = 0; tb_short = -1;
    endtask

    // Advance one clock and log any pulses seen just after the edge.
    task automatic tick1;
        @(posedge clk);
        #1;
        cyc++;
        if (a_short)  begin n_short++;  t_short = cyc;  end
        if (a_double) begin n_double++; t_double = cyc; end
        if (a_long)   begin n_long++;   t_long = cyc;   end
        if (a_rep) begin
            n_rep++;
            if (t_rep_first < 0) t_rep_first = cyc;
            t_rep_last = cyc;
        end
        if (int'(a_short) + int'(a_double) + int'(a_long) + int'(a_rep) > 1) n_excl++;
        if (b_short) begin nb_short++; tb_short = cyc; end
        if (b_double || b_long || b_rep) nb_other++;
    endtask

    task automatic run(input int n);
        repeat (n) tick1();
    endtask

    task automatic do_press;
        key_press = 1'b1;
        tick1();
        key_press = 1'b0;
    endtask

    task automatic do_release;
        key_release = 1'b1;
        tick1();
        key_release = 1'b0;
    endtask

    task automatic test_reset;
        clear_counts();
        rst = 1'b0;
        run(3);
        compared++;
        if ({a_short, a_double, a_long, a_rep, a_held} !== 5'b0) begin
            mismatched++; $display("FAIL reset_a_outputs: got %b want 00000", {a_short, a_double, a_long, a_rep, a_held});
        end
        compared++;
        if ({b_short, b_double, b_long, b_rep, b_held} !== 5'b0) begin
            mismatched++; $display("FAIL reset_b_outputs: got %b want 00000", {b_short, b_double, b_long, b_rep, b_held});
        end
        rst = 1'b1;
        run(3);
        compared++;
        if (a_held !== 1'b0) begin
            mismatched++; $display("FAIL reset_idle_held: got %b want 0", a_held);
        end
    endtask

    task automatic test_short;
        int c0, r0;
        clear_counts();
        do_press();
        c0 = cyc;
        compared++;
        if (a_held !== 1'b1) begin
            mismatched++; $display("FAIL short_held_on: got %b want 1", a_held);
        end
        run(3000 - 1);
        do_release();
        r0 = cyc;
        compared++;
        if (a_held !== 1'b0) begin
            mismatched++; $display("FAIL short_held_off: got %b want 0", a_held);
        end
        run(5500);
        compared++;
        if (n_short !== 1 || t_short !== r0 + 5000) begin
            mismatched++; $display("FAIL short_pulse: got count %0d at %0d want 1 at %0d (press %0d)", n_short, t_short, r0 + 5000, c0);
        end
        compared++;
        if (n_double + n_long + n_rep !== 0) begin
            mismatched++; $display("FAIL short_others: got %0d extra pulses want 0", n_double + n_long + n_rep);
        end
    endtask

    task automatic test_double;
        int r2;
        clear_counts();
        do_press();
        run(2000 - 1);
        do_release();
        run(2000 - 1);
        do_press();
        compared++;
        if (a_held !== 1'b1) begin
            mismatched++; $display("FAIL double_second_held: got %b want 1", a_held);
        end
        run(1000 - 1);
        do_release();
        r2 = cyc;
        run(6000);
        compared++;
        if (n_double !== 1 || t_double !== r2) begin
            mismatched++; $display("FAIL double_pulse: got count %0d at %0d want 1 at %0d", n_double, t_double, r2);
        end
        compared++;
        if (n_short + n_long + n_rep !== 0) begin
            mismatched++; $display("FAIL double_others: got %0d extra pulses want 0", n_short + n_long + n_rep);
        end
    endtask

    task automatic test_long;
        int c0;
        clear_counts();
        do_press();
        c0 = cyc;
        run(19000);
        compared++;
        if (n_long !== 1 || t_long !== c0 + 10000) begin
            mismatched++; $display("FAIL long_pulse: got count %0d at %0d want 1 at %0d", n_long, t_long, c0 + 10000);
        end
        compared++;
        if (n_rep !== 2 || t_rep_first !== c0 + 14000 || t_rep_last !== c0 + 18000) begin
            mismatched++; $display("FAIL long_repeat: got %0d pulses at %0d..%0d want 2 at %0d..%0d",
                                   n_rep, t_rep_first, t_rep_last, c0 + 14000, c0 + 18000);
        end
        compared++;
        if (a_held !== 1'b1) begin
            mismatched++; $display("FAIL long_held: got %b want 1", a_held);
        end
        do_release();
        run(6000);
        compared++;
        if (n_short + n_double !== 0 || n_rep !== 2 || a_held !== 1'b0) begin
            mismatched++; $display("FAIL long_release: got short+double %0d repeat %0d held %b want 0 2 0",
                                   n_short + n_double, n_rep, a_held);
        end
    endtask

    task automatic test_same_cycle;
        clear_counts();
        key_press = 1'b1;
        key_release = 1'b1;
        tick1();
        key_press = 1'b0;
        key_release = 1'b0;
        compared++;
        if (a_held !== 1'b0 || b_held !== 1'b0) begin
            mismatched++; $display("FAIL same_cycle_held: got %b%b want 00", a_held, b_held);
        end
        run(6000);
        compared++;
        if (n_short + n_double + n_long + n_rep + nb_short + nb_other !== 0) begin
            mismatched++; $display("FAIL same_cycle_pulses: got %0d want 0",
                                   n_short + n_double + n_long + n_rep + nb_short + nb_other);
        end
    endtask

    task automatic test_reset_mid;
        clear_counts();
        do_press();
        run(6000 - 1);
        rst = 1'b0;
        #2;
        compared++;
        if ({a_short, a_double, a_long, a_rep, a_held} !== 5'b0) begin
            mismatched++; $display("FAIL reset_mid_async: got %b want 00000", {a_short, a_double, a_long, a_rep, a_held});
        end
        run(1);
        rst = 1'b1;
        run(2000 - 2);
        do_release();
        run(12000);
        compared++;
        if (n_short + n_double + n_long + n_rep !== 0 || a_held !== 1'b0) begin
            mismatched++; $display("FAIL reset_mid_after: got pulses %0d held %b want 0 0",
                                   n_short + n_double + n_long + n_rep, a_held);
        end
        compared++;
        if (n_excl !== 0) begin
            mismatched++; $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", n_excl);
        end
    endtask

    task automatic test_dclick_off;
        int r0;
        clear_counts();
        do_press();
        run(1000 - 1);
        do_release();
        r0 = cyc;
        run(10);
        compared++;
        if (nb_short !== 1 || tb_short !== r0) begin
            mismatched++; $display("FAIL dclick_off_short: got count %0d at %0d want 1 at %0d", nb_short, tb_short, r0);
        end
        compared++;
        if (nb_other !== 0 || b_held !== 1'b0) begin
            mismatched++; $display("FAIL dclick_off_others: got %0d held %b want 0 0", nb_other, b_held);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_short();
        test_double();
        test_long();
        test_same_cycle();
        test_reset_mid();
        test_dclick_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_key_event_fsm
`default_nettype wire
